// File: rtl/decoder_nxm_seq.sv
// N-to-2**N registered one-hot decoder with an optional auto-scan mode.
// Define DECODER_NXM_SEQ_SCAN_EN to build in the SCAN state, dwell counter and wrap pulse.
module decoder_nxm_seq #(
  parameter int N     = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in,
  output logic              in_ready,
  output logic [2**N-1:0]   out,
  output logic              out_valid,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W = 2**N;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           wrap_q, wrap_d;
  logic           mode_eff;
  logic           accept;

`ifdef DECODER_NXM_SEQ_SCAN_EN
  localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);
  logic [7:0] cnt_q, cnt_d;
  assign mode_eff = mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_eff    = 1'b0;
`endif

  assign in_ready = en & ~mode_eff & ~rst;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
`ifdef DECODER_NXM_SEQ_SCAN_EN
    cnt_d       = cnt_q;
`endif
    if (en) begin
      if (accept) begin
        state_d     = DIRECT;
        idx_d       = in;
        out_d       = W'(1) << in;
        out_valid_d = 1'b1;
      end
`ifdef DECODER_NXM_SEQ_SCAN_EN
      else if (mode_eff) begin
        if (state_q != SCAN) begin
          state_d     = SCAN;
          idx_d       = '0;
          out_d       = W'(1);
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end else if (cnt_q == CNT_LAST) begin
          // End of dwell: advance the hot bit; idx wraps naturally at N bits.
          cnt_d  = '0;
          idx_d  = idx_q + 1'b1;
          out_d  = W'(1) << idx_d;
          wrap_d = (idx_q == '1);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else if (state_q == SCAN) begin
        state_d = DIRECT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
`ifdef DECODER_NXM_SEQ_SCAN_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
`ifdef DECODER_NXM_SEQ_SCAN_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Directed bench for decoder_nxm_seq (N=3, DWELL=2): vector table plus scan sequences.
module tb_decoder_nxm_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [2:0] in  = '0;
  logic       in_ready, out_valid, wrap;
  logic [7:0] out;
  logic [2:0] idx;

  int checks = 0;
  int errors = 0;

  decoder_nxm_seq #(.N(3), .DWELL(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, e, m, v;
    logic [2:0] d;
    logic       er;
    logic [7:0] eo;
    logic [2:0] ei;
    logic       ev;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input logic r, e, m, v, input logic [2:0] d);
    @(negedge clk);
    rst = r; en = e; mode = m; in_valid = v; in = d;
    #1;
  endtask

  task automatic obs(input string nm, input logic [7:0] eo, input logic [2:0] ei,
                     input logic ev, input logic ew);
    @(posedge clk);
    #1;
    chk({nm, " out"}, out, eo);
    chk({nm, " idx"}, {5'b0, idx}, {5'b0, ei});
    chk({nm, " out_valid"}, {7'b0, out_valid}, {7'b0, ev});
    chk({nm, " wrap"}, {7'b0, wrap}, {7'b0, ew});
  endtask

  initial begin
    // Direct-decode table: {rst,en,mode,in_valid,in} -> {in_ready, out, idx, out_valid}
    vt[0] = '{1, 1, 0, 1, 3'd5, 0, 8'h00, 3'd0, 0};
    for (int i = 0; i < 8; i++) begin
      logic [7:0] one;
      one = 8'h01;
      vt[i+1] = '{0, 1, 0, 1, 3'(i), 1, one << i, 3'(i), 1};
    end
    vt[9]  = '{0, 1, 0, 0, 3'd3, 1, 8'h80, 3'd7, 1};
    vt[10] = '{0, 0, 0, 1, 3'd2, 0, 8'h80, 3'd7, 1};
    vt[11] = '{0, 1, 0, 1, 3'd2, 1, 8'h04, 3'd2, 1};
    vt[12] = '{1, 1, 0, 1, 3'd6, 0, 8'h00, 3'd0, 0};
    vt[13] = '{0, 1, 0, 0, 3'd6, 1, 8'h00, 3'd0, 0};

    for (int i = 0; i < 14; i++) begin
      cyc(vt[i].r, vt[i].e, vt[i].m, vt[i].v, vt[i].d);
      chk($sformatf("vec%0d in_ready", i), {7'b0, in_ready}, {7'b0, vt[i].er});
      obs($sformatf("vec%0d", i), vt[i].eo, vt[i].ei, vt[i].ev, 1'b0);
    end

`ifdef DECODER_NXM_SEQ_SCAN_EN
    cyc(1, 1, 0, 0, 3'd0);
    obs("scan_rst", 8'h00, 3'd0, 0, 0);
    // Walk 0..7 then 0 with two cycles per index; continue to idx=3.
    for (int k = 1; k <= 23; k++) begin
      logic [2:0] ei;
      ei = 3'(((k - 1) / 2) % 8);
      cyc(0, 1, 1, 0, 3'd0);
      if (k == 1) chk("scan in_ready", {7'b0, in_ready}, 8'h00);
      obs($sformatf("scan k%0d", k), 8'h01 << ei, ei, 1, k == 17);
    end
    for (int j = 0; j < 5; j++) begin
      cyc(0, 0, 1, 1, 3'd6);
      obs($sformatf("freeze%0d", j), 8'h08, 3'd3, 1, 0);
    end
    // Dwell resumes mid-period: one more cycle at idx3, then idx4, idx4, idx5.
    for (int k = 24; k <= 27; k++) begin
      logic [2:0] ei;
      ei = 3'(((k - 1) / 2) % 8);
      cyc(0, 1, 1, 0, 3'd0);
      obs($sformatf("resume k%0d", k), 8'h01 << ei, ei, 1, 0);
    end
    cyc(0, 1, 0, 1, 3'd2);
    chk("scan2direct in_ready", {7'b0, in_ready}, 8'h01);
    obs("scan2direct", 8'h04, 3'd2, 1, 0);

    cyc(0, 1, 1, 1, 3'd7);
    chk("reentry in_ready", {7'b0, in_ready}, 8'h00);
    obs("reentry", 8'h01, 3'd0, 1, 0);
    cyc(0, 1, 1, 0, 3'd0);
    obs("reentry dwell", 8'h01, 3'd0, 1, 0);
    cyc(0, 1, 0, 0, 3'd0);
    obs("scan2direct hold", 8'h01, 3'd0, 1, 0);
    cyc(0, 1, 1, 0, 3'd0);
    obs("entry from direct", 8'h01, 3'd0, 1, 0);
    for (int j = 1; j <= 12; j++) begin
      logic [2:0] ei;
      ei = 3'(j / 2);
      cyc(0, 1, 1, 0, 3'd0);
      obs($sformatf("to6 j%0d", j), 8'h01 << ei, ei, 1, 0);
    end
    cyc(1, 1, 1, 1, 3'd3);
    chk("rst in_ready", {7'b0, in_ready}, 8'h00);
    obs("rst mid scan", 8'h00, 3'd0, 0, 0);
    cyc(1, 1, 0, 1, 3'd3);
    chk("rst iv in_ready", {7'b0, in_ready}, 8'h00);
    obs("rst with in_valid", 8'h00, 3'd0, 0, 0);
    cyc(0, 1, 0, 0, 3'd3);
    obs("post rst", 8'h00, 3'd0, 0, 0);
`else
    cyc(1, 1, 0, 0, 3'd0);
    obs("nomac rst", 8'h00, 3'd0, 0, 0);
    cyc(0, 1, 1, 1, 3'd4);
    chk("nomac in_ready", {7'b0, in_ready}, 8'h01);
    obs("nomac decode", 8'h10, 3'd4, 1, 0);
    for (int j = 0; j < 20; j++) begin
      cyc(0, 1, 1, 0, 3'd0);
      obs($sformatf("nomac hold%0d", j), 8'h10, 3'd4, 1, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_nxm_seq.md
DECODER_NXM_SEQ -- requirements
Module: decoder_nxm_seq

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter DWELL, default 4: cycles each output stays hot in scan mode; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  block enable; 0 freezes all state.
REQ-006 mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 in_valid  input  1  select word valid (direct mode).
REQ-008 in  input  N  binary select word.
REQ-009 in_ready  output  1  block accepts in this cycle.
REQ-010 out  output  2**N  registered one-hot decode; all-zero before first decode.
REQ-011 out_valid  output  1  out holds a valid one-hot value.
REQ-012 idx  output  N  binary index of the hot bit in out.
REQ-013 wrap  output  1  one-cycle pulse when scan index wraps from 2**N-1 to 0.

Function
REQ-014 The FSM SHALL have states IDLE, DIRECT and SCAN; reset enters IDLE.
REQ-015 in_ready SHALL be combinational: 1 iff en=1, mode=0 and rst=0.
REQ-016 Acceptance SHALL occur when in_valid=1 and in_ready=1.
REQ-017 On acceptance, the next cycle SHALL have out=1<<in, idx=in, out_valid=1 and state DIRECT; latency is exactly 1 cycle.
REQ-018 In DIRECT, out and idx SHALL hold until the next acceptance; in_valid=0 cycles change nothing.
REQ-019 Transition from IDLE or DIRECT to SCAN:
  - trigger: en=1 and mode=1;
  - next cycle: out=1, idx=0, out_valid=1, dwell counter=0.
REQ-020 In SCAN with en=1, the dwell counter SHALL count 0..DWELL-1.
REQ-021 When the dwell counter is at DWELL-1, it SHALL clear and idx SHALL advance by 1, modulo 2**N; out SHALL equal 1<<idx in the same cycle.
REQ-022 wrap SHALL be 1 for exactly the cycle in which idx shows 0 after a 2**N-1 -> 0 advance; it SHALL be 0 on scan entry and at all other times.
REQ-023 In SCAN, in_valid and in SHALL be ignored.
REQ-024 Transition SCAN -> DIRECT when mode=0 and en=1:
  - out, idx and out_valid hold their last values;
  - acceptance is possible in that same cycle.
REQ-025 When en=0, all registers SHALL hold and wrap SHALL be 0; the dwell count resumes where it stopped once en returns to 1.
REQ-026 out SHALL always be all-zero or exactly one-hot; out_valid=1 iff out is non-zero.
REQ-027 For N=1 the block SHALL decode to 2 outputs, and scan SHALL alternate between them.

Reset
REQ-028 When rst=1 at a clock edge, the next values SHALL be: out=0, out_valid=0, idx=0, wrap=0, dwell counter=0, state IDLE.
REQ-029 Reset SHALL take priority over en, mode and in_valid, including in the middle of a dwell period or on a wrap cycle.
REQ-030 An in_valid asserted during reset SHALL NOT be accepted.

Configuration
REQ-031 Macro DECODER_NXM_SEQ_SCAN_EN, when defined, SHALL compile in the SCAN state, the dwell counter and wrap generation.
REQ-032 Without the macro:
  - mode SHALL be ignored and treated as 0;
  - wrap SHALL be tied to 0;
  - no dwell counter logic SHALL exist;
  - all other behaviour is unchanged.

Verification (N=3, DWELL=2, macro defined unless stated)
REQ-033 Reset, then in_valid=1 with in=0..7 on consecutive cycles -> each following cycle out=8'b00000001..8'b10000000, idx=0..7, out_valid=1.
REQ-034 mode=1 for 17 cycles after IDLE -> out starts at 8'h01, and each bit is hot for 2 cycles; idx walks 0..7 then 0; wrap=1 only on the cycle idx returns to 0.
REQ-035 In SCAN at idx=3, drop en for 5 cycles, then restore it -> out stays 8'h08 and wrap=0 while en=0; the dwell count resumes with no skipped step.
REQ-036 In SCAN at idx=5, set mode=0 with in_valid=1, in=2 -> in_ready=1 that cycle, next cycle out=8'h04, idx=2.
REQ-037 Assert rst in the middle of SCAN at idx=6 -> next cycle out=0, out_valid=0, idx=0, wrap=0; in_valid=1 during reset leaves out at 0.
REQ-038 Macro undefined, mode=1 and in_valid=1 with in=4 -> out=8'h10 next cycle; wrap never asserts.
